// File: rtl/cp0_exc_ctrl_if.sv
// Commit-point bundle between the P7 pipeline and the CP0 exception responder.
// The pipeline drives the master side; cp0_exc_ctrl sits on the slave side.
interface cp0_exc_ctrl_if #(
  parameter int HWINT_W = 6
);
  logic [4:0]         cp0_addr;
  logic               cp0_we;
  logic [31:0]        cp0_wdata;
  logic [31:0]        cp0_rdata;
  logic [31:0]        cp0_pc;
  logic               cp0_bd;
  logic [4:0]         cp0_exc;
  logic [HWINT_W-1:0] cp0_hwint;
  logic               cp0_exl_clr;
  logic               cp0_req;
  logic [31:0]        cp0_epc;

  modport master (
    output cp0_addr, cp0_we, cp0_wdata, cp0_pc, cp0_bd, cp0_exc, cp0_hwint, cp0_exl_clr,
    input  cp0_rdata, cp0_req, cp0_epc
  );

  modport slave (
    input  cp0_addr, cp0_we, cp0_wdata, cp0_pc, cp0_bd, cp0_exc, cp0_hwint, cp0_exl_clr,
    output cp0_rdata, cp0_req, cp0_epc
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception responder: decides exception/interrupt entry,
// holds SR/Cause/EPC, serves mfc0/mtc0 and supplies EPC for eret.
module cp0_exc_ctrl #(
  parameter logic [31:0] PRID    = 32'h0000_7000,
  parameter int          HWINT_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  cp0_exc_ctrl_if.slave     bus
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [HWINT_W-1:0] im_reg;
  logic               exl_reg;
  logic               ie_reg;
  logic               bd_reg;
  logic [HWINT_W-1:0] ip_reg;
  logic [4:0]         exc_code_reg;
  logic [31:0]        epc_reg;

  logic [HWINT_W-1:0] pend;
  logic               int_req;
  logic               exc_req;
  logic               req;
  logic [31:0]        sr_word;
  logic [31:0]        cause_word;

  // A line is pending only when its mask bit is set.
  genvar gi;
  generate
    for (gi = 0; gi < HWINT_W; gi++) begin : g_pend
      assign pend[gi] = bus.cp0_hwint[gi] & im_reg[gi];
    end
  endgenerate

  assign int_req = !exl_reg && ie_reg && (|pend);
  assign exc_req = !exl_reg && (bus.cp0_exc != 5'd0);
  assign req     = int_req || exc_req;

  always_comb begin
    sr_word                  = '0;
    sr_word[10 +: HWINT_W]   = im_reg;
    sr_word[1]               = exl_reg;
    sr_word[0]               = ie_reg;
    cause_word               = '0;
    cause_word[31]           = bd_reg;
    cause_word[10 +: HWINT_W] = ip_reg;
    cause_word[6:2]          = exc_code_reg;
  end

  always_comb begin
    case (bus.cp0_addr)
      ADDR_SR:    bus.cp0_rdata = sr_word;
      ADDR_CAUSE: bus.cp0_rdata = cause_word;
      ADDR_EPC:   bus.cp0_rdata = epc_reg;
      ADDR_PRID:  bus.cp0_rdata = PRID;
      default:    bus.cp0_rdata = '0;
    endcase
  end

  assign bus.cp0_req = req;
  assign bus.cp0_epc = epc_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_reg       <= '0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= '0;
      epc_reg      <= '0;
    end else begin
      ip_reg <= bus.cp0_hwint;
      if (req) begin
        // Entry swallows any mtc0 or eret presented in the same cycle.
        exl_reg      <= 1'b1;
        bd_reg       <= bus.cp0_bd;
        exc_code_reg <= int_req ? 5'd0 : bus.cp0_exc;
        epc_reg      <= bus.cp0_bd ? bus.cp0_pc - 32'd4 : bus.cp0_pc;
      end else begin
        if (bus.cp0_we && bus.cp0_addr == ADDR_SR) begin
          im_reg  <= bus.cp0_wdata[10 +: HWINT_W];
          exl_reg <= bus.cp0_wdata[1];
          ie_reg  <= bus.cp0_wdata[0];
        end
        if (bus.cp0_we && bus.cp0_addr == ADDR_EPC) begin
          epc_reg <= bus.cp0_wdata;
        end
        // Placed after the SR write so eret wins for EXL.
        if (bus.cp0_exl_clr) begin
          exl_reg <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception responder for the P7 pipeline.
- Consumes the exception code, branch-delay flag and macro PC that the fetch/decode side attaches to each instruction, plus the six external hardware interrupt lines.
- Decides whether to take an exception or interrupt and asserts req, which redirects fetch to the handler at 0x4180.
- Records SR/Cause/EPC, serves mfc0/mtc0, and supplies EPC for eret.

Parameters:
PRID, 32'h0000_7000, constant value returned for register 15 (PRId)
HWINT_W, 6, number of hardware interrupt lines (Cause.IP / SR.IM width)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
cp0_addr  input  5  CP0 register index for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC, 15 PRId)
cp0_we  input  1  mtc0 write enable
cp0_wdata  input  32  mtc0 write data
cp0_rdata  output  32  mfc0 read data (combinational)
cp0_pc  input  32  macro PC of the instruction at the commit point
cp0_bd  input  1  that instruction is in a branch delay slot
cp0_exc  input  5  exception code of that instruction (0 none, 4 AdEL, 8 Syscall, 10 RI, others pass through)
cp0_hwint  input  6  external interrupt lines, level-sensitive
cp0_exl_clr  input  1  eret at commit point: clear EXL
cp0_req  output  1  take exception/interrupt this cycle (combinational)
cp0_epc  output  32  current EPC register value

Behaviour:
Register fields:
- SR: IM[15:10], EXL[1], IE[0]; all other bits read as 0.
- Cause: BD[31], IP[15:10], ExcCode[6:2]; all other bits read as 0.
- EPC: 32 bits.
- PRId: constant PRID.

Reset (rst low, asynchronous, any time including mid-handler):
- SR, Cause and EPC are 0.
- cp0_req is 0, since EXL=0 and IE=0 and cp0_exc is assumed 0 upstream during reset.
- cp0_epc = 0.

Request logic (combinational):
- int_req = !EXL & IE & |(cp0_hwint & IM).
- exc_req = !EXL & (cp0_exc != 0).
- cp0_req = int_req | exc_req.
- Interrupt has priority over exception on the same cycle.

On posedge clk with cp0_req=1:
- EXL <= 1.
- Cause.BD <= cp0_bd.
- ExcCode <= int_req ? 0 : cp0_exc.
- EPC <= cp0_bd ? cp0_pc - 4 : cp0_pc (32-bit wrap, no check).
- Any mtc0 and cp0_exl_clr in the same cycle are ignored.

Cause.IP:
- Cause.IP <= cp0_hwint every cycle, independent of req, we and EXL.
- The sampled value is visible to mfc0 one cycle later.

mtc0 (cp0_we=1, cp0_req=0):
- addr 12 writes IM, EXL and IE from the matching wdata bits.
- addr 14 writes EPC with full wdata.
- addr 13, addr 15 and other indices are ignored.

eret (cp0_exl_clr=1, cp0_req=0): EXL <= 0.
- If an mtc0 to SR occurs in the same cycle, the eret clear wins for EXL; the mtc0 still writes IM and IE.

mfc0:
- cp0_rdata is combinational from the current register state: 12/13/14/15 → SR/Cause/EPC/PRId, else 0.
- There is no write-through bypass.
- cp0_epc is the registered EPC; any bypass of a just-written EPC is the pipeline's job.

Nesting:
- While EXL=1, cp0_req stays 0 regardless of cp0_exc and cp0_hwint.
- Pending interrupts fire the first cycle after EXL clears, provided IE=1 and the line is still high.

Test Plan:
1. Reset: release rst, read addr 12/13/14/15 → 0, 0, 0, PRID; cp0_req=0.
2. Syscall, not in delay slot: cp0_exc=8, cp0_pc=0x3010, cp0_bd=0 → cp0_req=1 that cycle; next cycle Cause.ExcCode=8, BD=0, EPC=0x3010, EXL=1, cp0_req=0 even with cp0_exc=10 held.
3. Delay-slot RI: cp0_exc=10, cp0_pc=0x3024, cp0_bd=1 → EPC=0x3020, Cause=0x8000_0028.
4. Interrupt vs exception: mtc0 SR=0x0000_0401, then cp0_hwint=6'b000001 with cp0_exc=4 simultaneously → req=1, ExcCode=0; with IE=0, hwint alone gives req=0 but Cause.IP reads 0x0000_0400.
5. eret and re-entry: EXL=1 with hwint held high, pulse cp0_exl_clr → next cycle EXL=0 and cp0_req=1; mtc0 EPC=0x3100 then cp0_epc=0x3100 one cycle later.
6. Async reset mid-handler: EXL=1 and EPC=0x3050, drop rst between clock edges → SR/Cause/EPC read 0 immediately, before the next edge.
